// File: rtl/fpu_pkg.sv
// Shared FP32 adder types: field widths, operand class, FP32 layout and the align-stage payload.
package fpu_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned ADD_W = MAN_W + 5;
    localparam int unsigned SIG_W = MAN_W + 1;
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;

    // Encodings double as the out_special code.
    typedef enum logic [1:0] {
        FP_NORM = 2'b00,
        FP_ZERO = 2'b01,
        FP_INF  = 2'b10,
        FP_NAN  = 2'b11
    } fp_class_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        fp_class_e        cls;
    } fp_unpacked_t;

    typedef struct packed {
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [EXP_W-1:0] d;
        logic [SIG_W-1:0] sig_big;
        logic [SIG_W-1:0] sig_small;
        fp_class_e        cls;
    } s1_t;

    // Place a significand in addend format: ovf bit clear, guard/round/sticky clear.
    function automatic logic [ADD_W-1:0] sig_to_addend(input logic [SIG_W-1:0] sig);
        return {1'b0, sig, 3'b000};
    endfunction

endpackage

// File: rtl/fp_sticky_rshift.sv
// Logical right shift that ORs every bit shifted past bit 0 into bit 0.
module fp_sticky_rshift #(
    parameter int unsigned DATA_W = 28,
    parameter int unsigned SH_W   = 8
) (
    input  logic [DATA_W-1:0] din,
    input  logic [SH_W-1:0]   sh,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] lost_mask;
    logic              sticky;

    always_comb begin
        lost_mask = ~({DATA_W{1'b1}} << sh);
        sticky    = |(din & lost_mask);
        // Beyond DATA_W-1 the top bit is always shifted out, so only the sticky survives.
        if (sh >= SH_W'(DATA_W - 1)) begin
            dout = {{(DATA_W-1){1'b0}}, |din};
        end else begin
            dout = (din >> sh) | {{(DATA_W-1){1'b0}}, sticky};
        end
    end

endmodule

// File: rtl/fp_add_align.sv
// FP32 adder front end: unpack, magnitude order, align with sticky, pre-invert for subtraction.
// Optional build macro FP_ALIGN_DENORM_EN keeps subnormals; without it they flush to signed zero.
module fp_add_align
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_a,
    input  logic [FP_W-1:0]  in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADD_W-1:0] out_op_a,
    output logic [ADD_W-1:0] out_op_b,
    output logic             out_cin,
    output logic             out_eff_sub,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [1:0]       out_special
);

    logic             s1_valid;
    logic             s1_adv;
    s1_t              s1_q;
    s1_t              s1_d;
    fp32_t            a;
    fp32_t            b;
    fp_unpacked_t     ua;
    fp_unpacked_t     ub;
    logic             eb_sign;
    logic             eff_sub;
    logic             b_gt_a;
    logic             mag_eq;
    logic [ADD_W-1:0] small_addend;
    logic [ADD_W-1:0] small_aligned;

    function automatic fp_unpacked_t unpack(input fp32_t x);
        fp_unpacked_t u;
        u.exp = x.exp;
        u.sig = {1'b1, x.frac};
        u.cls = FP_NORM;
        if (x.exp == '1) begin
            u.cls = (x.frac == '0) ? FP_INF : FP_NAN;
        end else if (x.exp == '0) begin
`ifdef FP_ALIGN_DENORM_EN
            u.exp = EXP_W'(1);
            u.sig = {1'b0, x.frac};
            if (x.frac == '0) begin
                u.exp = '0;
                u.cls = FP_ZERO;
            end
`else
            u.sig = '0;
            u.cls = FP_ZERO;
`endif
        end
        return u;
    endfunction

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    assign a  = fp32_t'(in_a);
    assign b  = fp32_t'(in_b);
    assign ua = unpack(a);
    assign ub = unpack(b);

    // S1: order operands by magnitude and classify the pair.
    always_comb begin
        eb_sign = b.sign ^ in_sub;
        eff_sub = a.sign ^ eb_sign;
        b_gt_a  = {ub.exp, ub.sig} > {ua.exp, ua.sig};
        mag_eq  = {ub.exp, ub.sig} == {ua.exp, ua.sig};
        s1_d         = '0;
        s1_d.eff_sub = eff_sub;
        s1_d.cls     = FP_NORM;
        if (b_gt_a) begin
            s1_d.exp       = ub.exp;
            s1_d.d         = ub.exp - ua.exp;
            s1_d.sig_big   = ub.sig;
            s1_d.sig_small = ua.sig;
            s1_d.sign      = eb_sign;
        end else begin
            s1_d.exp       = ua.exp;
            s1_d.d         = ua.exp - ub.exp;
            s1_d.sig_big   = ua.sig;
            s1_d.sig_small = ub.sig;
            s1_d.sign      = a.sign;
        end
        if (mag_eq && eff_sub) begin
            s1_d.sign = 1'b0;
        end
        if (ua.cls == FP_NAN || ub.cls == FP_NAN) begin
            s1_d.cls  = FP_NAN;
            s1_d.sign = 1'b0;
        end else if (ua.cls == FP_INF && ub.cls == FP_INF) begin
            s1_d.cls  = eff_sub ? FP_NAN : FP_INF;
            s1_d.sign = eff_sub ? 1'b0 : a.sign;
        end else if (ua.cls == FP_INF) begin
            s1_d.cls  = FP_INF;
            s1_d.sign = a.sign;
        end else if (ub.cls == FP_INF) begin
            s1_d.cls  = FP_INF;
            s1_d.sign = eb_sign;
        end else if (ua.cls == FP_ZERO && ub.cls == FP_ZERO) begin
            s1_d.cls  = FP_ZERO;
            s1_d.sign = a.sign & eb_sign;
        end
        // Specials still produce a beat but feed zero addends to the adder.
        if (s1_d.cls != FP_NORM) begin
            s1_d.eff_sub   = 1'b0;
            s1_d.d         = '0;
            s1_d.sig_big   = '0;
            s1_d.sig_small = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    assign small_addend = sig_to_addend(s1_q.sig_small);

    fp_sticky_rshift #(
        .DATA_W (ADD_W),
        .SH_W   (EXP_W)
    ) u_rshift (
        .din  (small_addend),
        .sh   (s1_q.d),
        .dout (small_aligned)
    );

    // S2: register aligned addends; hold while the adder stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_op_a    <= '0;
            out_op_b    <= '0;
            out_cin     <= 1'b0;
            out_eff_sub <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_special <= '0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_op_a    <= sig_to_addend(s1_q.sig_big);
                out_op_b    <= s1_q.eff_sub ? ~small_aligned : small_aligned;
                out_cin     <= s1_q.eff_sub;
                out_eff_sub <= s1_q.eff_sub;
                out_sign    <= s1_q.sign;
                out_exp     <= s1_q.exp;
                out_special <= s1_q.cls;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_align.sv
// Directed-vector bench for fp_add_align: table vectors, backpressure stream, reset flush.
module tb_fp_add_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [27:0] out_op_a;
    logic [27:0] out_op_b;
    logic        out_cin;
    logic        out_eff_sub;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [1:0]  out_special;

    fp_add_align dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_sub      (in_sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op_a    (out_op_a),
        .out_op_b    (out_op_b),
        .out_cin     (out_cin),
        .out_eff_sub (out_eff_sub),
        .out_sign    (out_sign),
        .out_exp     (out_exp),
        .out_special (out_special)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [27:0] op_a;
        logic [27:0] op_b;
        logic        cin;
        logic        eff_sub;
        logic        sign;
        logic [7:0]  exp;
        logic [1:0]  special;
        logic        full;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    function automatic logic [68:0] act_bits();
        return {out_op_a, out_op_b, out_cin, out_eff_sub, out_sign, out_exp, out_special};
    endfunction

    function automatic logic [68:0] exp_bits(input vec_t v);
        return {v.op_a, v.op_b, v.cin, v.eff_sub, v.sign, v.exp, v.special};
    endfunction

    function automatic logic [68:0] vec_mask(input vec_t v);
        logic [68:0] m;
        m = '1;
        if (!v.full) m[10:2] = '0;
        return m;
    endfunction

    task automatic drive(input vec_t v);
        in_a     = v.a;
        in_b     = v.b;
        in_sub   = v.sub;
        in_valid = 1'b1;
    endtask

    task automatic run_vec(input int i);
        string nm;
        nm = $sformatf("vec%0d", i);
        @(negedge clk);
        out_ready = 1'b1;
        drive(vecs[i]);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_lat1"}, 69'(out_valid), 69'(0));
        @(negedge clk);
        check({nm, "_lat2"}, 69'(out_valid), 69'(1));
        check(nm, act_bits() & vec_mask(vecs[i]), exp_bits(vecs[i]) & vec_mask(vecs[i]));
    endtask

    initial begin
        int tx;
        int rx;
        int extra;
        int stale;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 28'h4000000, 28'h4000000, 1'b0, 1'b0, 1'b0, 8'h7F, 2'b00, 1'b1};
        vecs[1]  = '{32'h3F800000, 32'h3F000000, 1'b1, 28'h4000000, 28'hDFFFFFF, 1'b1, 1'b1, 1'b0, 8'h7F, 2'b00, 1'b1};
        vecs[2]  = '{32'h3F800000, 32'h30800000, 1'b0, 28'h4000000, 28'h0000001, 1'b0, 1'b0, 1'b0, 8'h7F, 2'b00, 1'b1};
        vecs[3]  = '{32'h3F000000, 32'hBF800000, 1'b0, 28'h4000000, 28'hDFFFFFF, 1'b1, 1'b1, 1'b1, 8'h7F, 2'b00, 1'b1};
        vecs[4]  = '{32'h40400000, 32'h40400000, 1'b1, 28'h6000000, 28'h9FFFFFF, 1'b1, 1'b1, 1'b0, 8'h80, 2'b00, 1'b1};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 28'h0000000, 28'h0000000, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 1'b0};
        vecs[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 28'h0000000, 28'h0000000, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 1'b0};
        vecs[7]  = '{32'h7F800000, 32'h7F800000, 1'b1, 28'h0000000, 28'h0000000, 1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 1'b0};
        vecs[8]  = '{32'hFF800000, 32'h3F800000, 1'b0, 28'h0000000, 28'h0000000, 1'b0, 1'b0, 1'b1, 8'hFF, 2'b10, 1'b1};
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 28'h0000000, 28'h0000000, 1'b0, 1'b0, 1'b1, 8'h00, 2'b01, 1'b1};
        vecs[10] = '{32'h00000000, 32'h80000000, 1'b1, 28'h0000000, 28'h0000000, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 1'b1};
        vecs[11] = '{32'h41800000, 32'h3F800001, 1'b0, 28'h4000000, 28'h0400001, 1'b0, 1'b0, 1'b0, 8'h83, 2'b00, 1'b1};
        vecs[12] = '{32'h41800000, 32'h3F800001, 1'b1, 28'h4000000, 28'hFBFFFFE, 1'b1, 1'b1, 1'b0, 8'h83, 2'b00, 1'b1};
`ifdef FP_ALIGN_DENORM_EN
        vecs[13] = '{32'h00000001, 32'h00000000, 1'b0, 28'h0000008, 28'h0000000, 1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b1};
`else
        vecs[13] = '{32'h00000001, 32'h00000000, 1'b0, 28'h0000000, 28'h0000000, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 1'b1};
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 69'(in_ready), 69'(1));
        check("rst_out_valid", 69'(out_valid), 69'(0));
        check("rst_outputs", act_bits(), 69'(0));

        for (int i = 0; i < NV; i++) run_vec(i);

        // Backpressure: 4 beats, adder stalled for the first 6 cycles.
        tx = 0;
        rx = 0;
        extra = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            if (tx < 4) drive(vecs[tx]);
            else in_valid = 1'b0;
            #1;
            if (cyc == 5) begin
                check("bp_accepted", 69'(tx), 69'(2));
                check("bp_in_ready", 69'(in_ready), 69'(0));
                check("bp_out_valid", 69'(out_valid), 69'(1));
            end
            if (out_valid) begin
                if (rx < 4) check($sformatf("bp_beat%0d_c%0d", rx, cyc), act_bits(), exp_bits(vecs[rx]));
                else extra++;
                if (out_ready) rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid = 1'b0;
        check("bp_beats_out", 69'(rx), 69'(4));
        check("bp_no_dup", 69'(extra), 69'(0));

        // Reset with two beats in flight drops both.
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[1]);
        @(negedge clk);
        drive(vecs[3]);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("fill_out_valid", 69'(out_valid), 69'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 69'(out_valid), 69'(0));
        check("rst_mid_outputs", act_bits(), 69'(0));
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("rst_no_stale", 69'(stale), 69'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
